// File: rtl/draw_datapath.sv
// draw_datapath: pixel generator for a 160x120 VGA adapter.
//
// The block has one FSM: IDLE -> FILL/CURS/ERAS -> DONE -> IDLE.
//   FILL : 80x60 rectangle at the captured (inX,inY) in the captured colour.
//   CURS : 8x8 cursor at (px,py) in white (3'd7).
//   ERAS : 8x8 cursor area restored to each pixel's quadrant background.
// Each scan emits one pixel per cycle in row-major order.
// The cursor position (px,py) changes only in IDLE, through load or move.
//
// Optional feature (macro CURSOR_OUTLINE_EN): CURS plots only the 28-pixel
// outer ring of the 8x8 area and keeps plot low on the interior. The scan
// still takes 64 cycles. ERAS is not affected.
//
// Ports:
//   CLOCK_50    in   clock; all state changes on its rising edge
//   reset       in   synchronous active-high reset
//   inX/inY     in   base coordinates (fill origin or cursor load position)
//   inColour    in   fill colour
//   fill_req    in   request a quadrant fill (level)
//   load        in   load cursor position from inX/inY
//   draw/erase  in   request a cursor draw or erase (level)
//   move/dir    in   step the cursor 8 px (0=up 1=down 2=left 3=right)
//   vga_x/vga_y/vga_colour/plot  out  pixel write to the VGA adapter
//   done        out  one-cycle pulse when an operation completes
//   busy        out  high outside IDLE
module draw_datapath (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] inX,
    input  logic [6:0] inY,
    input  logic [2:0] inColour,
    input  logic       fill_req,
    input  logic       load,
    input  logic       draw,
    input  logic       erase,
    input  logic       move,
    input  logic [1:0] dir,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       done,
    output logic       busy
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_CURS, S_ERAS, S_DONE} state_t;

    state_t     state_reg, state_next;
    logic [6:0] cx_reg, cx_next;
    logic [5:0] cy_reg, cy_next;
    logic [7:0] bx_reg, bx_next;
    logic [6:0] by_reg, by_next;
    logic [2:0] colour_reg, colour_next;
    logic [7:0] px_reg, px_next;
    logic [6:0] py_reg, py_next;

    logic [6:0] last_col;
    logic [5:0] last_row;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic       ring;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cx_reg     <= '0;
            cy_reg     <= '0;
            bx_reg     <= '0;
            by_reg     <= '0;
            colour_reg <= '0;
            px_reg     <= 8'd72;
            py_reg     <= 7'd52;
        end else begin
            state_reg  <= state_next;
            cx_reg     <= cx_next;
            cy_reg     <= cy_next;
            bx_reg     <= bx_next;
            by_reg     <= by_next;
            colour_reg <= colour_next;
            px_reg     <= px_next;
            py_reg     <= py_next;
        end
    end

    // Scan extent depends on the operation: 80x60 for fill, 8x8 otherwise.
    always_comb begin
        last_col = (state_reg == S_FILL) ? 7'd79 : 7'd7;
        last_row = (state_reg == S_FILL) ? 6'd59 : 6'd7;
    end

    always_comb begin
        state_next  = state_reg;
        cx_next     = cx_reg;
        cy_next     = cy_reg;
        bx_next     = bx_reg;
        by_next     = by_reg;
        colour_next = colour_reg;
        px_next     = px_reg;
        py_next     = py_reg;
        case (state_reg)
            S_IDLE: begin
                cx_next = '0;
                cy_next = '0;
                if (fill_req) begin
                    state_next  = S_FILL;
                    bx_next     = inX;
                    by_next     = inY;
                    colour_next = inColour;
                end else if (erase || draw) begin
                    // Cursor scans use the cursor position as their base, so
                    // the scan datapath is shared with the fill.
                    state_next = erase ? S_ERAS : S_CURS;
                    bx_next    = px_reg;
                    by_next    = py_reg;
                end else if (load) begin
                    px_next = inX;
                    py_next = inY;
                end else if (move) begin
                    // Clamp so the 8x8 cursor stays inside 160x120.
                    case (dir)
                        2'd0: py_next = (py_reg < 7'd8)    ? 7'd0   : py_reg - 7'd8;
                        2'd1: py_next = (py_reg >= 7'd104) ? 7'd112 : py_reg + 7'd8;
                        2'd2: px_next = (px_reg < 8'd8)    ? 8'd0   : px_reg - 8'd8;
                        default: px_next = (px_reg >= 8'd144) ? 8'd152 : px_reg + 8'd8;
                    endcase
                end
            end
            S_FILL, S_CURS, S_ERAS: begin
                if (cx_reg == last_col) begin
                    cx_next = '0;
                    if (cy_reg == last_row) begin
                        cy_next    = '0;
                        state_next = S_DONE;
                    end else begin
                        cy_next = cy_reg + 6'd1;
                    end
                end else begin
                    cx_next = cx_reg + 7'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Sums wrap at port width; keeping regions on screen is up to the caller.
    always_comb begin
        pix_x = bx_reg + {1'b0, cx_reg};
        pix_y = by_reg + {1'b0, cy_reg};
        ring  = (cx_reg == 7'd0) || (cx_reg == 7'd7) ||
                (cy_reg == 6'd0) || (cy_reg == 6'd7);
    end

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        plot       = 1'b0;
        done       = (state_reg == S_DONE);
        busy       = (state_reg != S_IDLE);
        case (state_reg)
            S_FILL: begin
                plot       = 1'b1;
                vga_x      = pix_x;
                vga_y      = pix_y;
                vga_colour = colour_reg;
            end
            S_CURS: begin
`ifdef CURSOR_OUTLINE_EN
                plot       = ring;
`else
                plot       = 1'b1;
`endif
                vga_x      = pix_x;
                vga_y      = pix_y;
                vga_colour = 3'd7;
            end
            S_ERAS: begin
                plot  = 1'b1;
                vga_x = pix_x;
                vga_y = pix_y;
                // Quadrant backgrounds: 1 TL, 2 TR, 4 BL, 6 BR.
                case ({pix_y >= 7'd60, pix_x >= 8'd80})
                    2'b00:   vga_colour = 3'd1;
                    2'b01:   vga_colour = 3'd2;
                    2'b10:   vga_colour = 3'd4;
                    default: vga_colour = 3'd6;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_draw_datapath.sv
module tb_draw_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] inX;
    logic [6:0] inY;
    logic [2:0] inColour;
    logic       fill_req, load, draw, erase, move;
    logic [1:0] dir;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot, done, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    draw_datapath dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .inX       (inX),
        .inY       (inY),
        .inColour  (inColour),
        .fill_req  (fill_req),
        .load      (load),
        .draw      (draw),
        .erase     (erase),
        .move      (move),
        .dir       (dir),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .plot      (plot),
        .done      (done),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {plot, x, y, colour} as seen at the current sampling point.
    function automatic logic [18:0] pix_now();
        return {plot, vga_x, vga_y, vga_colour};
    endfunction

    function automatic logic [18:0] pix_exp(input int x, input int y, input int c);
        logic [7:0] xx;
        logic [6:0] yy;
        logic [2:0] cc;
        xx = x[7:0];
        yy = y[6:0];
        cc = c[2:0];
        return {1'b1, xx, yy, cc};
    endfunction

    task automatic pulse_load(input int x, input int y);
        inX  = x[7:0];
        inY  = y[6:0];
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        $display("load (%0d,%0d)", x, y);
    endtask

    task automatic pulse_move(input int d);
        dir  = d[1:0];
        move = 1'b1;
        @(negedge clk);
        move = 1'b0;
        $display("move dir=%0d", d);
    endtask

    // Runs one 8x8 cursor draw or erase and checks every pixel, done and
    // the return to idle. With disturb set, load/move are pulsed mid-scan.
    task automatic scan(input string tag, input bit is_erase, input int bx,
                        input int by, input bit disturb);
        int x, y, c, r, col;
        bit on;
        if (is_erase) erase = 1'b1; else draw = 1'b1;
        @(negedge clk);
        erase = 1'b0;
        draw  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            r = i / 8;
            col = i % 8;
            x = bx + col;
            y = by + r;
            if (disturb && i == 10) begin
                move = 1'b1; dir = 2'd0; load = 1'b1; inX = 8'd0; inY = 7'd0;
            end
            if (disturb && i == 11) begin
                move = 1'b0; load = 1'b0;
            end
            if (is_erase) begin
                if (x < 80 && y < 60)  c = 1;
                else if (y < 60)       c = 2;
                else if (x < 80)       c = 4;
                else                   c = 6;
                on = 1'b1;
            end else begin
                c = 7;
`ifdef CURSOR_OUTLINE_EN
                on = (r == 0) || (r == 7) || (col == 0) || (col == 7);
`else
                on = 1'b1;
`endif
            end
            if (on)
                chk({tag, "_pix"}, {13'd0, pix_now()}, {13'd0, pix_exp(x, y, c)});
            else
                chk({tag, "_noplot"}, {31'd0, plot}, 32'd0);
            @(negedge clk);
        end
        chk({tag, "_done"}, {29'd0, done, plot, busy}, 32'b101);
        @(negedge clk);
        chk({tag, "_idle"}, {29'd0, done, plot, busy}, 32'b000);
        $display("%s at (%0d,%0d) complete", tag, bx, by);
    endtask

    initial begin
        reset = 1'b1;
        inX = '0; inY = '0; inColour = '0;
        fill_req = 1'b0; load = 1'b0; draw = 1'b0; erase = 1'b0; move = 1'b0;
        dir = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {10'd0, plot, done, busy, vga_x, vga_y, vga_colour}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        $display("reset released");

        // Priority: all three requests together must pick the fill.
        fill_req = 1'b1; erase = 1'b1; draw = 1'b1;
        inX = 8'd80; inY = 7'd60; inColour = 3'd6;
        @(negedge clk);
        erase = 1'b0; draw = 1'b0;
        for (int i = 0; i < 4800; i++) begin
            chk("fill_pix", {13'd0, pix_now()}, {13'd0, pix_exp(80 + i % 80, 60 + i / 80, 6)});
            @(negedge clk);
        end
        chk("fill_done", {29'd0, done, plot, busy}, 32'b101);
        $display("fill (80,60) colour 6 complete");
        // fill_req still held: a fresh fill follows the idle cycle.
        inX = 8'd0; inY = 7'd0; inColour = 3'd3;
        @(negedge clk);
        chk("fill_idle", {29'd0, done, plot, busy}, 32'b000);
        @(negedge clk);
        chk("refill_first", {13'd0, pix_now()}, {13'd0, pix_exp(0, 0, 3)});
        fill_req = 1'b0;
        repeat (99) @(negedge clk);
        chk("refill_pix99", {13'd0, pix_now()}, {13'd0, pix_exp(19, 1, 3)});
        $display("refill (0,0) colour 3 started, aborting");

        // Abort by reset mid-fill.
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outs", {29'd0, done, plot, busy}, 32'b000);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_nodone", {30'd0, done, busy}, 32'd0);
        end

        // Cursor back at (72,52) after reset.
        scan("draw_reset", 1'b0, 72, 52, 1'b0);
        scan("erase_reset", 1'b1, 72, 52, 1'b0);

        // Straddle all four quadrants.
        pulse_load(76, 56);
        scan("erase_straddle", 1'b1, 76, 56, 1'b0);

        // Clamp at the bottom-right corner.
        pulse_load(152, 112);
        pulse_move(3);
        pulse_move(1);
        scan("draw_clamp", 1'b0, 152, 112, 1'b0);
        pulse_move(2);
        // Load and move during the scan must be ignored.
        scan("draw_left", 1'b0, 144, 112, 1'b1);
        scan("draw_masked", 1'b0, 144, 112, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
